// File: rtl/capture_ctrl_of_verifla_pkg.sv
`default_nettype none
// ============================================================================
// Module   : capture_ctrl_of_verifla_pkg
// Purpose  : Shared defaults, state encoding and word-width helper for the
//            VeriFLA capture controller.
// Revision : 1.0  initial release
// ============================================================================
package capture_ctrl_of_verifla_pkg;

   localparam int DEF_DW   = 8;
   localparam int DEF_IDB  = 8;
   localparam int DEF_AW   = 8;
   localparam int DEF_LAST = 255;
   localparam int DEF_BT   = 64;
   localparam logic [7:0] DEF_TRIG_VALUE = 8'h00;
   localparam logic [7:0] DEF_TRIG_MASK  = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PRETRIG  = 2'd1,
      ST_POSTTRIG = 2'd2,
      ST_DONE     = 2'd3
   } cap_state_e;

   function automatic int mem_word_bits(input int dw, input int idb);
      return dw + idb;
   endfunction

   localparam int DEF_WORD_BITS = mem_word_bits(DEF_DW, DEF_IDB);

endpackage
`default_nettype wire

// File: rtl/capture_ctrl_of_verifla_rle.sv
`default_nettype none
// ============================================================================
// Module   : capture_rle_of_verifla
// Purpose  : Run-length tracker; decides whether a sample extends the current
//            memory word or starts a new one, and supplies the repeat count.
// Revision : 1.0  initial release
// ============================================================================
module capture_rle_of_verifla #(
   parameter int DW  = 8,
   parameter int IDB = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           clear_i,
   input  logic           sample_i,
   input  logic           force_new_i,
   input  logic [DW-1:0]  data_i,
   output logic           new_word_o,
   output logic [IDB-1:0] count_o
);

   logic [DW-1:0]  prev_q;
   logic [IDB-1:0] cnt_q;
   logic           w_same;

   // A saturated count can never be extended, so it forces a fresh word.
   assign w_same     = !force_new_i && (data_i == prev_q) && (cnt_q != '1);
   assign new_word_o = !w_same;
   assign count_o    = w_same ? cnt_q + 1'b1 : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q <= '0;
         cnt_q  <= '0;
      end else if (clear_i) begin
         cnt_q  <= '0;
      end else if (sample_i) begin
         prev_q <= data_i;
         cnt_q  <= count_o;
      end
   end

endmodule
`default_nettype wire

// File: rtl/capture_ctrl_of_verifla.sv
`default_nettype none
// ============================================================================
// Module   : capture_ctrl_of_verifla
// Purpose  : Logic-analyzer write-side controller: circular pre-trigger
//            buffer, masked trigger, linear post-trigger fill, optional
//            run-length compression (enabled by LA_RLE_COMPRESS_EN).
// Revision : 1.0  initial release
// ============================================================================
module capture_ctrl_of_verifla
   import capture_ctrl_of_verifla_pkg::*;
#(
   parameter int LA_DATA_INPUT_WORDLEN_BITS = DEF_DW,
   parameter int LA_IDENTICAL_SAMPLES_BITS  = DEF_IDB,
   parameter int LA_MEM_ADDRESS_BITS        = DEF_AW,
   parameter int LA_MEM_LAST_ADDR           = DEF_LAST,
   parameter int LA_BEFORE_TRIGGER_WORDS    = DEF_BT,
   parameter logic [LA_DATA_INPUT_WORDLEN_BITS-1:0] LA_TRIGGER_VALUE =
      LA_DATA_INPUT_WORDLEN_BITS'(DEF_TRIG_VALUE),
   parameter logic [LA_DATA_INPUT_WORDLEN_BITS-1:0] LA_TRIGGER_MASK =
      LA_DATA_INPUT_WORDLEN_BITS'(DEF_TRIG_MASK)
) (
   input  logic                                  clka,
   input  logic                                  rst,
   input  logic                                  arm,
   input  logic                                  sample_en,
   input  logic [LA_DATA_INPUT_WORDLEN_BITS-1:0] data_in,
   output logic [LA_MEM_ADDRESS_BITS-1:0]        addra,
   output logic                                  wea,
   output logic [mem_word_bits(LA_DATA_INPUT_WORDLEN_BITS,
                               LA_IDENTICAL_SAMPLES_BITS)-1:0] dina,
   output logic                                  busy,
   output logic                                  capture_done,
   output logic                                  trigger_seen,
   output logic [LA_MEM_ADDRESS_BITS-1:0]        bt_tail,
   output logic                                  bt_wrapped
);

   localparam int DW  = LA_DATA_INPUT_WORDLEN_BITS;
   localparam int IDB = LA_IDENTICAL_SAMPLES_BITS;
   localparam int AW  = LA_MEM_ADDRESS_BITS;
   localparam int WB  = mem_word_bits(DW, IDB);
   localparam logic [AW-1:0] C_LAST_ADDR = AW'(LA_MEM_LAST_ADDR);
   localparam logic [AW-1:0] C_BT_FIRST  = AW'(LA_BEFORE_TRIGGER_WORDS);
   localparam logic [AW-1:0] C_BT_LAST   = AW'(LA_BEFORE_TRIGGER_WORDS - 1);

   cap_state_e    state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] tail_q, tail_d;
   logic [WB-1:0] dina_q, dina_d;
   logic          wea_q, wea_d;
   logic          first_q, first_d;
   logic          trig_q, trig_d;
   logic          wrap_q, wrap_d;

   logic           w_match;
   logic           w_new_word;
   logic [IDB-1:0] w_count;
   logic [AW-1:0]  w_pre_next;

   assign w_match    = ((data_in ^ LA_TRIGGER_VALUE) & LA_TRIGGER_MASK) == '0;
   assign w_pre_next = (first_q || addr_q == C_BT_LAST) ? '0 : addr_q + 1'b1;

`ifdef LA_RLE_COMPRESS_EN
   logic w_commit;
   logic w_rle_clear;

   // The sample that runs off the end of memory is dropped, so it must not
   // disturb the run tracker either.
   assign w_commit = sample_en &&
                     ((state_q == ST_PRETRIG) ||
                      (state_q == ST_POSTTRIG && !(w_new_word && addr_q == C_LAST_ADDR)));
   assign w_rle_clear = arm && (state_q == ST_IDLE || state_q == ST_DONE);

   capture_rle_of_verifla #(
      .DW  (DW),
      .IDB (IDB)
   ) u_rle (
      .clk         (clka),
      .rst         (rst),
      .clear_i     (w_rle_clear),
      .sample_i    (w_commit),
      .force_new_i (first_q || (state_q == ST_PRETRIG && w_match)),
      .data_i      (data_in),
      .new_word_o  (w_new_word),
      .count_o     (w_count)
   );
`else
   assign w_new_word = 1'b1;
   assign w_count    = '0;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      tail_d  = tail_q;
      dina_d  = dina_q;
      wea_d   = 1'b0;
      first_d = first_q;
      trig_d  = trig_q;
      wrap_d  = wrap_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (arm) begin
               state_d = ST_PRETRIG;
               addr_d  = '0;
               first_d = 1'b1;
               trig_d  = 1'b0;
               wrap_d  = 1'b0;
            end
         end
         ST_PRETRIG: begin
            if (sample_en) begin
               wea_d   = 1'b1;
               first_d = 1'b0;
               dina_d  = {w_count, data_in};
               if (w_match) begin
                  state_d = ST_POSTTRIG;
                  addr_d  = C_BT_FIRST;
                  tail_d  = w_pre_next;
                  trig_d  = 1'b1;
               end else if (w_new_word) begin
                  addr_d = w_pre_next;
                  if (!first_q && addr_q == C_BT_LAST) begin
                     wrap_d = 1'b1;
                  end
               end
            end
         end
         ST_POSTTRIG: begin
            if (sample_en) begin
               if (w_new_word && addr_q == C_LAST_ADDR) begin
                  state_d = ST_DONE;
               end else begin
                  wea_d  = 1'b1;
                  dina_d = {w_count, data_in};
                  if (w_new_word) begin
                     addr_d = addr_q + 1'b1;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         tail_q  <= '0;
         dina_q  <= '0;
         wea_q   <= 1'b0;
         first_q <= 1'b0;
         trig_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         tail_q  <= tail_d;
         dina_q  <= dina_d;
         wea_q   <= wea_d;
         first_q <= first_d;
         trig_q  <= trig_d;
         wrap_q  <= wrap_d;
      end
   end

   assign addra        = addr_q;
   assign wea          = wea_q;
   assign dina         = dina_q;
   assign busy         = (state_q == ST_PRETRIG) || (state_q == ST_POSTTRIG);
   assign capture_done = (state_q == ST_DONE);
   assign trigger_seen = trig_q;
   assign bt_tail      = tail_q;
   assign bt_wrapped   = wrap_q;

endmodule
`default_nettype wire

// File: doc/capture_ctrl_of_verifla.md
Name: capture_ctrl_of_verifla

Overview:
Upstream write-side controller for the logic-analyzer sample memory. It watches the probed data bus and run-length compresses identical consecutive samples. It maintains a circular pre-trigger region and detects the masked trigger pattern. It then fills the post-trigger region linearly and drives the memory write port (addra/wea/dina). On completion it flags the readout/transmit stage with the pre-trigger wrap point.

Parameters:
LA_DATA_INPUT_WORDLEN_BITS, 8, width of probed data bus
LA_IDENTICAL_SAMPLES_BITS, 8, width of repeat-count field
LA_MEM_ADDRESS_BITS, 8, memory address width
LA_MEM_LAST_ADDR, 255, highest memory address
LA_BEFORE_TRIGGER_WORDS, 64, size of circular pre-trigger region (addresses 0..BT-1); 1 <= BT <= LAST
LA_TRIGGER_VALUE, 8'h00, trigger compare value
LA_TRIGGER_MASK, 8'hFF, compare mask; 1 = bit participates

Ports:
clka  in  1  single clock; all state on posedge
rst  in  1  asynchronous, active-high reset
arm  in  1  one-cycle pulse; starts capture from IDLE or DONE
sample_en  in  1  sample qualifier; data_in ignored when low
data_in  in  DW  probed signals
addra  out  AW  memory write address
wea  out  1  memory write enable
dina  out  IDB+DW  memory word {repeat_count, data}
busy  out  1  high in PRETRIG/POSTTRIG
capture_done  out  1  high in DONE
trigger_seen  out  1  set on trigger, cleared on arm
bt_tail  out  AW  address of oldest pre-trigger word, latched at trigger
bt_wrapped  out  1  pre-trigger region wrapped at least once before trigger

Behaviour:
- Reset: all outputs 0, state IDLE, count 0, internal prev-data 0. Reset mid-capture aborts immediately; no further writes.
- Outputs are registered. A write for the sample presented at edge N appears on addra/wea/dina after edge N, and is consumed by the memory at edge N+1.
- States:
  - IDLE: wea=0. arm -> PRETRIG with wptr=0, new-word flag set.
  - PRETRIG: on each sample_en cycle, compare (data_in & MASK) == (VALUE & MASK).
    - Match -> POSTTRIG. The trigger sample is written as a fresh word at address BT with count 0. bt_tail <= current pre-trigger next-word slot; trigger_seen <= 1.
    - No match -> store the sample in the circular region. Address wraps BT-1 -> 0, setting bt_wrapped.
  - POSTTRIG: linear writes from BT upward. When a new word is needed and addra == LAST, that sample is discarded, wea=0, -> DONE.
  - DONE: wea=0, outputs held. arm -> PRETRIG, clearing trigger_seen, bt_wrapped and count.
- arm in PRETRIG/POSTTRIG is ignored.
- Run-length compression:
  - If data_in == prev_data and count != all-ones, increment count and rewrite the same address with {count, data}. Every enabled sample yields wea=1.
  - Otherwise advance the address and write {0, data_in}.
  - First sample after arm always starts a new word at address 0.
- sample_en=0: wea=0; no state, count or trigger evaluation change.
- Simultaneous trigger and count saturation: trigger wins, so the new word goes at BT.
- Count saturation: forces a new word at the next address (wrap rules apply).

Optional Feature:
LA_RLE_COMPRESS_EN
- Defined: run-length compression as above.
- Undefined: every enabled sample writes a new word at the next address. Count field is tied to 0. prev_data and count registers are removed.

Decomposition:
- Shared package/config include: word widths, LA_MEM_LAST_ADDR, BT size, trigger value/mask, state encoding (IDLE=0, PRETRIG=1, POSTTRIG=2, DONE=3), and a derived memory-word width constant.
- One natural sub-module: capture_rle_of_verifla. It holds prev_data/count, and emits new_word and the {count, data} word.

Test Plan:
- Reset then arm; feed 0x11,0x22,0x33 with no trigger -> writes addr0={0,11}, addr1={0,22}, addr2={0,33}; busy=1.
- Feed 0x55 for 4 cycles (RLE on) -> addr k rewritten with counts 0,1,2,3; address stays at k.
- BT=4: feed 6 distinct non-trigger values, then the trigger -> bt_wrapped=1, bt_tail=2, trigger word at addr 4, trigger_seen=1.
- Post-trigger: feed distinct values until addr LAST is written -> next sample not written, capture_done=1, wea=0. A second arm returns to PRETRIG with flags cleared.
- Constant data with IDB=2 -> counts 0..3, then a new word at the next address. Assert rst mid-POSTTRIG -> all outputs 0 asynchronously; no write on the next edge.
- LA_RLE_COMPRESS_EN undefined: feed 0x55 ×3 -> three addresses, each {0,55}.
